quant_pipe: RTL and testbench



---
 rtl/quant_pipe.sv | 139 +++++++++++++
 tb/tb_quant_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_pipe.sv
// quant_pipe: two-stage JPEG quantiser. Multiplies each lane of a DCT row by a
// reciprocal from a programmable luma/chroma table, then rounds and saturates.

module quant_lane #(
    parameter int PW     = 19,
    parameter int FRAC_W = 7,
    parameter int OUT_W  = 10
) (
    input  logic [PW-1:0]    prod,
    output logic [OUT_W-1:0] res
);
    localparam logic [FRAC_W-1:0]    HALF = {1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [PW-1:0] MAXV = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] q, r;
    logic                 up;

    // Floor shift plus a conditional increment gives round-half-away-from-zero.
    always_comb begin
        q  = $signed(prod) >>> FRAC_W;
        up = prod[PW-1] ? (prod[FRAC_W-1:0] > HALF) : (prod[FRAC_W-1:0] >= HALF);
        r  = q + {{(PW-1){1'b0}}, up};
        if (r > MAXV)      res = MAXV[OUT_W-1:0];
        else if (r < MINV) res = MINV[OUT_W-1:0];
        else               res = r[OUT_W-1:0];
    end
endmodule

module quant_pipe #(
    parameter int LANES  = 8,
    parameter int IN_W   = 10,
    parameter int OUT_W  = 10,
    parameter int COEF_W = 8,
    parameter int FRAC_W = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   table_sel,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_row,
    output logic                   out_last,
    input  logic                   tbl_we,
    input  logic [6:0]             tbl_addr,
    input  logic [COEF_W-1:0]      tbl_wdata
);
    localparam int PW = IN_W + COEF_W + 1;

    localparam int LUMA_D [64] = '{
        32, 11, 12, 8, 5, 3, 2, 2,
        10, 10,  9, 6, 4, 2, 2, 2,
         9,  9,  8, 5, 3, 2, 1, 2,
         9,  7,  5, 4, 2, 1, 1, 2,
         7,  5,  3, 2, 1, 1, 1, 1,
         5,  3,  2, 2, 1, 1, 1, 1,
         2,  2,  1, 1, 1, 1, 1, 1,
         1,  1,  1, 1, 1, 1, 1, 1};
    localparam int CHROMA_D [64] = '{
         8,  7,  5, 3, 1, 1, 1, 1,
         7,  6,  5, 2, 1, 1, 1, 1,
         5,  5,  2, 1, 1, 1, 1, 1,
         3,  2,  1, 1, 1, 1, 1, 1,
         1,  1,  1, 1, 1, 1, 1, 1,
         1,  1,  1, 1, 1, 1, 1, 1,
         1,  1,  1, 1, 1, 1, 1, 1,
         1,  1,  1, 1, 1, 1, 1, 1};

    // Packed index i holds lane LANES-1-i so lane 0 lands in the MSBs.
    logic [LANES-1:0][IN_W-1:0]  in_lanes;
    logic [LANES-1:0][PW-1:0]    prod_d, s1_prod;
    logic [LANES-1:0][OUT_W-1:0] res_d, out_lanes;
    logic [COEF_W-1:0]           tbl [128];
    logic [2:1]                  vld_pipe;
    logic [2:0]                  row_cnt, s1_row;
    logic                        s1_last, blk_tsel, tsel, adv, accept;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign out_valid = vld_pipe[2];
    assign tsel      = (row_cnt == 3'd0) ? table_sel : blk_tsel;
    assign in_lanes  = in_data;
    assign out_data  = out_lanes;

    for (genvar i = 0; i < LANES; i++) begin : g_mul
        logic signed [PW-1:0] a, b;
        assign a         = {{(PW-IN_W){in_lanes[i][IN_W-1]}}, in_lanes[i]};
        assign b         = {{(PW-COEF_W){1'b0}}, tbl[{tsel, row_cnt, 3'(LANES-1-i)}]};
        assign prod_d[i] = a * b;
    end

    quant_lane #(.PW(PW), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) u_lane [LANES-1:0] (
        .prod (s1_prod),
        .res  (res_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            s1_prod   <= '0;
            s1_row    <= '0;
            s1_last   <= 1'b0;
            out_lanes <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            row_cnt   <= '0;
            blk_tsel  <= 1'b0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[1], accept};
            s1_prod   <= prod_d;
            s1_row    <= row_cnt;
            s1_last   <= (row_cnt == 3'd7);
            out_lanes <= res_d;
            out_row   <= s1_row;
            out_last  <= s1_last;
            if (accept) begin
                row_cnt <= row_cnt + 3'd1;
                if (row_cnt == 3'd0) blk_tsel <= table_sel;
            end
        end
    end

    // Writes land at the edge, so a coincident accept reads the old coefficient.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) begin
                tbl[k]      <= COEF_W'(LUMA_D[k]);
                tbl[k + 64] <= COEF_W'(CHROMA_D[k]);
            end
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_wdata;
        end
    end
endmodule

// File: tb/tb_quant_pipe.sv
// Scoreboard bench for quant_pipe: a behavioural model predicts each row at
// accept time, and rows are compared in order as the DUT hands them over.
module tb_quant_pipe;
    localparam int LANES = 8, IN_W = 10, OUT_W = 10, COEF_W = 8, FRAC_W = 7;
    localparam int DW = LANES * OUT_W;

    logic                  clk = 1'b0, reset = 1'b1;
    logic [LANES*IN_W-1:0] in_data = '0;
    logic                  in_valid = 1'b0, in_ready, table_sel = 1'b0;
    logic [DW-1:0]         out_data;
    logic                  out_valid, out_ready = 1'b1, out_last;
    logic [2:0]            out_row;
    logic                  tbl_we = 1'b0;
    logic [6:0]            tbl_addr = '0;
    logic [COEF_W-1:0]     tbl_wdata = '0;

    quant_pipe #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .table_sel(table_sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata));

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    row;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] obs_data[$];
    logic [2:0]    obs_row[$];
    int            n_cmp = 0, n_err = 0;
    int            tbl_m[128];
    int            row_m = 0, blk_m = 0;
    int            lane_v[LANES];

    int luma_d[64] = '{32,11,12,8,5,3,2,2, 10,10,9,6,4,2,2,2, 9,9,8,5,3,2,1,2, 9,7,5,4,2,1,1,2,
                       7,5,3,2,1,1,1,1, 5,3,2,2,1,1,1,1, 2,2,1,1,1,1,1,1, 1,1,1,1,1,1,1,1};
    int chroma_d[64] = '{8,7,5,3,1,1,1,1, 7,6,5,2,1,1,1,1, 5,5,2,1,1,1,1,1, 3,2,1,1,1,1,1,1,
                         1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1};

    function automatic void load_defaults();
        for (int k = 0; k < 64; k++) begin
            tbl_m[k]      = luma_d[k];
            tbl_m[k + 64] = chroma_d[k];
        end
    endfunction

    // Divide the magnitude with a half-step bias, then restore the sign and clamp.
    function automatic logic [OUT_W-1:0] qmodel(int x, int c);
        int p, m, r;
        p = x * c;
        m = (p < 0) ? -p : p;
        r = (m + (1 << (FRAC_W - 1))) / (1 << FRAC_W);
        if (p < 0) r = -r;
        if (r > 511) r = 511;
        if (r < -512) r = -512;
        return OUT_W'(r);
    endfunction

    function automatic logic [LANES*IN_W-1:0] pack_in();
        logic [LANES*IN_W-1:0] v;
        v = '0;
        for (int j = 0; j < LANES; j++) v[(LANES-1-j)*IN_W +: IN_W] = IN_W'(lane_v[j]);
        return v;
    endfunction

    // Model and scoreboard; transfers commit at the following rising edge.
    always @(negedge clk) begin
        exp_t                  e;
        logic signed [IN_W-1:0] xs;
        int                    ts;
        if (reset) begin
            sb.delete();
            row_m = 0;
            blk_m = 0;
            load_defaults();
        end else begin
            if (out_valid && out_ready) begin
                obs_data.push_back(out_data);
                obs_row.push_back(out_row);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got row %0d data %h, expected no output", out_row, out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_row, out_last} !== {e.data, e.row, e.last}) begin
                        n_err++;
                        $display("FAIL sb_row: got data %h row %0d last %b, expected data %h row %0d last %b",
                                 out_data, out_row, out_last, e.data, e.row, e.last);
                    end
                end
            end
            if (in_valid && in_ready) begin
                ts = (row_m == 0) ? int'(table_sel) : blk_m;
                for (int j = 0; j < LANES; j++) begin
                    xs = in_data[(LANES-1-j)*IN_W +: IN_W];
                    e.data[(LANES-1-j)*OUT_W +: OUT_W] = qmodel(int'(xs), tbl_m[ts*64 + row_m*8 + j]);
                end
                e.row  = 3'(row_m);
                e.last = (row_m == 7);
                sb.push_back(e);
                if (row_m == 0) blk_m = int'(table_sel);
                row_m = (row_m + 1) % 8;
            end
            if (tbl_we) tbl_m[tbl_addr] = int'(tbl_wdata);
        end
    end

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; tbl_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        obs_data.delete();
        obs_row.delete();
    endtask

    task automatic send_row(input logic tsel);
        in_valid = 1'b1; in_data = pack_in(); table_sel = tsel;
        @(posedge clk); #1;
    endtask

    task automatic zero_lanes();
        for (int j = 0; j < LANES; j++) lane_v[j] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_data: got %h, expected 0", out_data); end
        n_cmp++; if ({out_row, out_last} !== 4'b0) begin n_err++; $display("FAIL rst_row: got row %0d last %b, expected 0/0", out_row, out_last); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, expected 1", in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d;
        exp_d = {10'h019, 10'h3FC, 10'h000, 10'h000, 10'h000, 10'h000, 10'h001, 10'h3FF};
        do_reset();
        zero_lanes();
        lane_v[0] = 100; lane_v[1] = -45; lane_v[6] = 32; lane_v[7] = -32;
        send_row(1'b0);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat1: out_valid %b, expected 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_lat2: out_valid %b, expected 1", out_valid); end
        n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL basic_data: got %h, expected %h", out_data, exp_d); end
        n_cmp++; if (out_row !== 3'd0) begin n_err++; $display("FAIL basic_row: got %0d, expected 0", out_row); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_counter();
        logic tsel;
        do_reset();
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < LANES; j++) lane_v[j] = int'($urandom_range(1023)) - 512;
            if (r % 8 == 0) lane_v[0] = 128;
            tsel = (r == 0) ? 1'b1 : (r == 8) ? 1'b0 : 1'(r % 2);
            send_row(tsel);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_row.size() != 16) begin
            n_err++; $display("FAIL cnt_count: got %0d rows, expected 16", obs_row.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_cmp++;
                if (obs_row[k] !== 3'(k % 8)) begin n_err++; $display("FAIL cnt_row: index %0d got %0d, expected %0d", k, obs_row[k], k % 8); end
            end
            n_cmp++; if (obs_data[0][DW-1 -: OUT_W] !== 10'd8) begin n_err++; $display("FAIL cnt_chroma: got %0d, expected 8", obs_data[0][DW-1 -: OUT_W]); end
            n_cmp++; if (obs_data[8][DW-1 -: OUT_W] !== 10'd32) begin n_err++; $display("FAIL cnt_luma: got %0d, expected 32", obs_data[8][DW-1 -: OUT_W]); end
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL cnt_drain: %0d rows left, expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int            k = 0, c = 0, acc_stall = 0;
        logic          acc, prev_ok = 1'b0;
        logic [DW-1:0] prev = '0;
        do_reset();
        while (k < 10 && c < 100) begin
            out_ready = (c >= 5);
            for (int j = 0; j < LANES; j++) lane_v[j] = ((k * 61 + j * 29) % 1000) - 500;
            in_valid = 1'b1; in_data = pack_in(); table_sel = 1'b0;
            @(negedge clk);
            acc = in_ready;
            if (c < 5) begin
                if (acc) acc_stall++;
                if (out_valid) begin
                    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b, expected 0", in_ready); end
                    if (prev_ok) begin
                        n_cmp++; if (out_data !== prev) begin n_err++; $display("FAIL bp_stable: got %h, expected %h", out_data, prev); end
                    end
                    prev = out_data; prev_ok = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (acc) k++;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (k != 10) begin n_err++; $display("FAIL bp_timeout: accepted %0d rows, expected 10", k); end
        n_cmp++; if (acc_stall != 2) begin n_err++; $display("FAIL bp_captured: got %0d, expected 2", acc_stall); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (obs_row.size() != 10) begin n_err++; $display("FAIL bp_count: got %0d rows, expected 10", obs_row.size()); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL bp_drain: %0d rows left, expected 0", sb.size()); end
    endtask

    task automatic test_saturation();
        do_reset();
        tbl_we = 1'b1; tbl_addr = 7'd0; tbl_wdata = 8'd255;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        zero_lanes(); lane_v[0] = 511;
        send_row(1'b0);
        zero_lanes();
        repeat (7) send_row(1'b0);
        lane_v[0] = -512;
        send_row(1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_data.size() < 9) begin
            n_err++; $display("FAIL sat_count: got %0d rows, expected 9", obs_data.size());
        end else begin
            n_cmp++; if (obs_data[0][DW-1 -: OUT_W] !== 10'h1FF) begin n_err++; $display("FAIL sat_pos: got %h, expected 1ff", obs_data[0][DW-1 -: OUT_W]); end
            n_cmp++; if (obs_data[8][DW-1 -: OUT_W] !== 10'h200) begin n_err++; $display("FAIL sat_neg: got %h, expected 200", obs_data[8][DW-1 -: OUT_W]); end
        end
        do_reset();
        zero_lanes(); lane_v[0] = 511;
        tbl_we = 1'b1; tbl_addr = 7'd0; tbl_wdata = 8'd255;
        send_row(1'b0);
        tbl_we = 1'b0;
        zero_lanes();
        repeat (7) send_row(1'b0);
        lane_v[0] = 511;
        send_row(1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_data.size() < 9) begin
            n_err++; $display("FAIL wr_count: got %0d rows, expected 9", obs_data.size());
        end else begin
            n_cmp++; if (obs_data[0][DW-1 -: OUT_W] !== 10'h080) begin n_err++; $display("FAIL wr_old: got %h, expected 080", obs_data[0][DW-1 -: OUT_W]); end
            n_cmp++; if (obs_data[8][DW-1 -: OUT_W] !== 10'h1FF) begin n_err++; $display("FAIL wr_new: got %h, expected 1ff", obs_data[8][DW-1 -: OUT_W]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tbl_we = 1'b1; tbl_addr = 7'd0; tbl_wdata = 8'd255;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        zero_lanes(); lane_v[0] = 128;
        repeat (4) send_row(1'b0);
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b, expected 0", out_valid); end
        reset = 1'b0;
        obs_data.delete();
        obs_row.delete();
        send_row(1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_row.size() != 1) begin
            n_err++; $display("FAIL mid_count: got %0d rows, expected 1", obs_row.size());
        end else begin
            n_cmp++; if (obs_row[0] !== 3'd0) begin n_err++; $display("FAIL mid_row: got %0d, expected 0", obs_row[0]); end
            n_cmp++; if (obs_data[0][DW-1 -: OUT_W] !== 10'd32) begin n_err++; $display("FAIL mid_table: got %0d, expected 32", obs_data[0][DW-1 -: OUT_W]); end
        end
    endtask

    initial begin
        load_defaults();
        zero_lanes();
        test_reset();
        test_basic();
        test_counter();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
